// File: rtl/fetch_queue_if.sv
// Fetch/Decode handshake bundle for the fetch_queue instruction buffer.
// The master side is Fetch+Decode (the environment); the slave side is the queue.
interface fetch_queue_if #(
    parameter int PTR_W = 3
) ();
    logic             flush;
    logic             in_valid;
    logic [31:0]      in_instruction;
    logic [31:0]      in_pc;
    logic             in_ready;
    logic             fetch_complete;
    logic             out_valid;
    logic [31:0]      out_instruction;
    logic [31:0]      out_pc;
    logic             out_ready;
    logic [PTR_W:0]   count;
    logic             almost_full;
    logic             drained;

    modport master (
        output flush, in_valid, in_instruction, in_pc, fetch_complete, out_ready,
        input  in_ready, out_valid, out_instruction, out_pc, count, almost_full, drained
    );

    modport slave (
        input  flush, in_valid, in_instruction, in_pc, fetch_complete, out_ready,
        output in_ready, out_valid, out_instruction, out_pc, count, almost_full, drained
    );
endinterface

// File: rtl/fetch_queue.sv
// In-order instruction buffer between Fetch and Decode: first-word-fall-through FIFO
// with one-cycle enqueue-to-visible latency, flush, and end-of-program drain tracking.
module fetch_queue #(
    parameter int DEPTH           = 8,
    parameter int PTR_W           = 3,
    parameter int ALMOST_FULL_LVL = 6
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.slave  q
);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] AF_CNT    = (PTR_W+1)'(ALMOST_FULL_LVL);
    localparam logic [PTR_W:0] ZERO_CNT  = '0;

    logic [31:0]      mem_instr_q [DEPTH];
    logic [31:0]      mem_pc_q    [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             done_seen_q, done_seen_d;
    logic             drained_q, drained_d;

    logic             enq;
    logic             deq;
    logic             wr_en;
    logic             full;
    logic             empty;

    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == ZERO_CNT);
    assign enq   = q.in_valid && !full;
    assign deq   = q.out_ready && !empty;

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        wr_en       = 1'b0;
        done_seen_d = done_seen_q | q.fetch_complete;
        if (q.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) begin
                wr_en  = 1'b1;
                tail_d = tail_q + 1'b1;
            end
            if (deq) begin
                head_d = head_q + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
        // Registered from next-state so it rises the cycle after the last dequeue.
        drained_d = done_seen_d && (count_d == ZERO_CNT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            done_seen_q <= 1'b0;
            drained_q   <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            done_seen_q <= done_seen_d;
            drained_q   <= drained_d;
        end
    end

    // Storage is not reset; the head outputs are masked while empty instead.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_instr_q[tail_q] <= q.in_instruction;
            mem_pc_q[tail_q]    <= q.in_pc;
        end
    end

    assign q.in_ready        = !full;
    assign q.out_valid       = !empty;
    assign q.out_instruction = empty ? 32'h0 : mem_instr_q[head_q];
    assign q.out_pc          = empty ? 32'h0 : mem_pc_q[head_q];
    assign q.count           = count_q;
    assign q.almost_full     = (count_q >= AF_CNT);
    assign q.drained         = drained_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: order, back-pressure, full+dequeue, flush, drain, reset.
module tb_fetch_queue;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    fetch_queue_if #(.PTR_W(3)) bus ();

    fetch_queue #(.DEPTH(8), .PTR_W(3), .ALMOST_FULL_LVL(6)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_in(input logic v, input logic [31:0] pc, input logic [31:0] ins);
        bus.in_valid       = v;
        bus.in_pc          = pc;
        bus.in_instruction = ins;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.flush          = 1'b0;
        bus.fetch_complete = 1'b0;
        bus.out_ready      = 1'b0;
        drive_in(1'b0, 32'h0, 32'h0);
        cyc();
        cyc();
        reset = 1'b0;

        // Reset state
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_instr", bus.out_instruction, 32'h0);
        chk("rst_out_pc", bus.out_pc, 32'h0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_almost_full", 32'(bus.almost_full), 32'd0);
        chk("rst_drained", 32'(bus.drained), 32'd0);

        // 1. Basic order with out_ready held high
        bus.out_ready = 1'b1;
        drive_in(1'b1, 32'h0, 32'h00500093);
        chk("t1_no_bypass", 32'(bus.out_valid), 32'd0);
        cyc();
        chk("t1_pc0", bus.out_pc, 32'h0);
        chk("t1_ins0", bus.out_instruction, 32'h00500093);
        chk("t1_cnt0", 32'(bus.count), 32'd1);
        drive_in(1'b1, 32'h4, 32'h00A00113);
        cyc();
        chk("t1_pc1", bus.out_pc, 32'h4);
        chk("t1_ins1", bus.out_instruction, 32'h00A00113);
        chk("t1_cnt1", 32'(bus.count), 32'd1);
        drive_in(1'b1, 32'h8, 32'h002081B3);
        cyc();
        chk("t1_pc2", bus.out_pc, 32'h8);
        chk("t1_ins2", bus.out_instruction, 32'h002081B3);
        chk("t1_cnt2", 32'(bus.count), 32'd1);
        drive_in(1'b0, 32'h0, 32'h0);
        cyc();
        chk("t1_empty_cnt", 32'(bus.count), 32'd0);
        chk("t1_empty_valid", 32'(bus.out_valid), 32'd0);
        chk("t1_empty_pc", bus.out_pc, 32'h0);

        // 2. Fill with back-pressure for 10 cycles
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive_in(1'b1, 32'(i * 4), 32'h1000 + 32'(i));
            chk($sformatf("t2_in_ready_%0d", i), 32'(bus.in_ready), (i < 8) ? 32'd1 : 32'd0);
            cyc();
            chk($sformatf("t2_count_%0d", i), 32'(bus.count), (i < 8) ? 32'(i + 1) : 32'd8);
            chk($sformatf("t2_af_%0d", i), 32'(bus.almost_full), (i >= 5) ? 32'd1 : 32'd0);
        end
        chk("t2_head_pc", bus.out_pc, 32'h0);
        chk("t2_head_ins", bus.out_instruction, 32'h1000);

        // 3. Full with simultaneous dequeue: the offered entry must be refused
        drive_in(1'b1, 32'h100, 32'hDEAD0000);
        bus.out_ready = 1'b1;
        chk("t3_in_ready_full", 32'(bus.in_ready), 32'd0);
        cyc();
        chk("t3_count7", 32'(bus.count), 32'd7);
        chk("t3_in_ready_back", 32'(bus.in_ready), 32'd1);
        chk("t3_pc4", bus.out_pc, 32'h4);
        chk("t3_ins4", bus.out_instruction, 32'h1001);
        drive_in(1'b1, 32'h20, 32'h1008);
        cyc();
        chk("t3_count7b", 32'(bus.count), 32'd7);
        chk("t3_pc8", bus.out_pc, 32'h8);
        drive_in(1'b0, 32'h0, 32'h0);
        for (int j = 3; j <= 8; j++) begin
            cyc();
            chk($sformatf("t3_wrap_pc_%0d", j), bus.out_pc, 32'(j * 4));
            chk($sformatf("t3_wrap_ins_%0d", j), bus.out_instruction, 32'h1000 + 32'(j));
        end
        cyc();
        chk("t3_drain_cnt", 32'(bus.count), 32'd0);
        chk("t3_drain_valid", 32'(bus.out_valid), 32'd0);

        // Empty: out_ready is ignored
        cyc();
        chk("empty_no_underflow", 32'(bus.count), 32'd0);

        // 4. Flush with simultaneous enqueue and dequeue
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_in(1'b1, 32'h40 + 32'(i * 4), 32'h2000 + 32'(i));
            cyc();
        end
        chk("t4_count5", 32'(bus.count), 32'd5);
        chk("t4_head_pc", bus.out_pc, 32'h40);
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        drive_in(1'b1, 32'h80, 32'h00000BAD);
        cyc();
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        drive_in(1'b0, 32'h0, 32'h0);
        chk("t4_flush_cnt", 32'(bus.count), 32'd0);
        chk("t4_flush_valid", 32'(bus.out_valid), 32'd0);
        chk("t4_flush_pc", bus.out_pc, 32'h0);
        chk("t4_flush_in_ready", 32'(bus.in_ready), 32'd1);
        cyc();
        chk("t4_not_stored", 32'(bus.count), 32'd0);
        drive_in(1'b1, 32'h90, 32'h1234);
        cyc();
        drive_in(1'b0, 32'h0, 32'h0);
        chk("t4_post_pc", bus.out_pc, 32'h90);
        chk("t4_post_ins", bus.out_instruction, 32'h1234);
        chk("t4_post_cnt", 32'(bus.count), 32'd1);
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
        chk("t4_post_empty", 32'(bus.count), 32'd0);
        chk("t4_drained_pre", 32'(bus.drained), 32'd0);

        // 5. Drain tracking
        for (int i = 0; i < 3; i++) begin
            drive_in(1'b1, 32'hA0 + 32'(i * 4), 32'h3000 + 32'(i));
            cyc();
        end
        drive_in(1'b0, 32'h0, 32'h0);
        bus.fetch_complete = 1'b1;
        cyc();
        bus.fetch_complete = 1'b0;
        chk("t5_drained_cnt3", 32'(bus.drained), 32'd0);
        bus.out_ready = 1'b1;
        cyc();
        chk("t5_drained_cnt2", 32'(bus.drained), 32'd0);
        cyc();
        chk("t5_drained_cnt1", 32'(bus.drained), 32'd0);
        chk("t5_last_pc", bus.out_pc, 32'hA8);
        cyc();
        chk("t5_drained_set", 32'(bus.drained), 32'd1);
        chk("t5_cnt0", 32'(bus.count), 32'd0);
        cyc();
        chk("t5_drained_hold", 32'(bus.drained), 32'd1);
        bus.out_ready = 1'b0;
        bus.flush     = 1'b1;
        cyc();
        bus.flush = 1'b0;
        chk("t5_drained_flush", 32'(bus.drained), 32'd1);

        // 6. Reset mid-run with done_seen set
        for (int i = 0; i < 4; i++) begin
            drive_in(1'b1, 32'hC0 + 32'(i * 4), 32'h4000 + 32'(i));
            cyc();
        end
        drive_in(1'b0, 32'h0, 32'h0);
        chk("t6_cnt4", 32'(bus.count), 32'd4);
        chk("t6_drained_busy", 32'(bus.drained), 32'd0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("t6_rst_cnt", 32'(bus.count), 32'd0);
        chk("t6_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("t6_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_rst_pc", bus.out_pc, 32'h0);
        chk("t6_rst_drained", 32'(bus.drained), 32'd0);
        cyc();
        chk("t6_done_cleared", 32'(bus.drained), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction buffer between the Fetch stage and the Decode stage of the out-of-order RISC-V core.
- Accepts one fetched instruction and its PC per cycle, and presents them in program order to Decode through a valid/ready handshake.
- Lets Fetch run ahead while Decode is back-pressured by a full RS, ROB or LSQ.
- Latches end-of-program from Fetch and reports when every buffered instruction has been handed to Decode.

Parameters:
- DEPTH, 8, number of entries; must be a power of 2 and at least 2.
- PTR_W, 3, pointer width; must equal log2(DEPTH).
- ALMOST_FULL_LVL, 6, occupancy at or above which almost_full asserts; valid range 1..DEPTH.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-high reset.
- flush, input, 1, synchronous clear of all buffered entries.
- in_valid, input, 1, Fetch presents an instruction this cycle.
- in_instruction, input, 32, instruction word (already byte-swapped by Fetch).
- in_pc, input, 32, PC of in_instruction.
- in_ready, output, 1, queue can accept an entry this cycle.
- fetch_complete, input, 1, Fetch has reached rom_size; no further in_valid will arrive.
- out_valid, output, 1, head entry is valid.
- out_instruction, output, 32, head instruction.
- out_pc, output, 32, head PC.
- out_ready, input, 1, Decode consumes the head this cycle.
- count, output, PTR_W+1, current occupancy, 0..DEPTH.
- almost_full, output, 1, count >= ALMOST_FULL_LVL.
- drained, output, 1, end-of-program seen and queue empty.

Behaviour:
- Reset (synchronous, highest priority):
  - head_ptr, tail_ptr, count and done_seen are cleared to 0.
  - Storage contents are don't-care.
  - Outputs after reset: in_ready=1, out_valid=0, out_instruction=0, out_pc=0, count=0, almost_full=0, drained=0.
- Enqueue fires when in_valid && in_ready:
  - the pair {in_pc, in_instruction} is written at tail_ptr;
  - tail_ptr increments modulo DEPTH (natural PTR_W-bit wrap).
- Dequeue fires when out_valid && out_ready:
  - head_ptr increments modulo DEPTH.
- Head presentation:
  - out_instruction and out_pc are driven from the entry at head_ptr (first-word-fall-through).
  - Both are forced to 0 whenever out_valid=0.
- Status outputs:
  - in_ready = (count != DEPTH). It is computed from the registered count only, with no same-cycle dequeue credit.
  - out_valid = (count != 0).
  - Latency: an entry enqueued in cycle N is visible at out_* in cycle N+1. There is no same-cycle bypass, including when the queue is empty.
- Count update each cycle: +1 on enqueue only, -1 on dequeue only, unchanged when both or neither fire.
- Full: in_ready=0, so in_valid is ignored and Fetch must hold its PC. A dequeue in that cycle lowers count to DEPTH-1, and in_ready rises in the next cycle.
- Empty: out_ready is ignored. count never underflows and pointers do not move.
- Flush (below reset, above enqueue/dequeue):
  - head_ptr, tail_ptr and count are cleared; any same-cycle enqueue or dequeue is discarded.
  - done_seen is NOT cleared.
- End of program:
  - done_seen sets on the first cycle fetch_complete=1 and stays set until reset.
  - drained = done_seen && (count == 0), registered. It asserts in the cycle after the last dequeue, or after fetch_complete is seen with an empty queue.
- Zero words: the queue does not filter all-zero instructions; Fetch is responsible for end-of-ROM detection.
- Reset mid-operation: all buffered entries are lost, and the next cycle behaves exactly as after power-on reset.

Test Plan:
1. Basic order: enqueue PCs 0x0, 0x4, 0x8 with instructions 0x00500093, 0x00A00113, 0x002081B3, out_ready=1 → the same three appear in order, each one cycle after its enqueue; count peaks at 1.
2. Fill and back-pressure: out_ready=0, in_valid=1 for 10 cycles → 8 entries accepted; in_ready=0 from the 9th cycle; almost_full=1 once count=6; raising out_ready yields PCs 0x0..0x1C in order, and pointers wrap correctly on refill.
3. Full with simultaneous dequeue: count=8, in_valid=1, out_ready=1 → no enqueue that cycle; count=7; in_ready=1 in the next cycle.
4. Flush: count=5 with flush=1 together with in_valid=1 and out_ready=1 → next cycle count=0, out_valid=0, out_pc=0; the flushed-cycle input is not stored.
5. Drain: enqueue 3 entries, pulse fetch_complete, dequeue all → drained=0 until the cycle after the third dequeue, then stays 1; a later flush keeps drained=1.
6. Reset mid-run: count=4 and done_seen=1, assert reset for one cycle → count=0, in_ready=1, out_valid=0, drained=0.
